// File: rtl/multi_delay_filter.sv
// Multi-channel glitch-reject / delay filter.
// Each channel synchronises its raw input through two flops and lets the
// filtered level follow only after the new level has been seen for NUM
// consecutive enabled clocks. Registered rise/fall pulses mark each commit.
module multi_delay_filter #(
  parameter int CH   = 8,
  parameter int NUM  = 10,
  parameter int INIT = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iEn,
  input  logic [CH-1:0] iSig,
  output logic [CH-1:0] oSignal,
  output logic [CH-1:0] oRise,
  output logic [CH-1:0] oFall,
  output logic [CH-1:0] oBusy
);

  localparam int CNT_W  = $clog2(NUM + 1);
  localparam logic INIT_L = (INIT == 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } state_t;

  if (NUM < 1 || (INIT != 0 && INIT != 1)) begin : g_param_err
    $fatal(1, "multi_delay_filter: NUM must be >= 1 and INIT must be 0 or 1");
  end

  logic [CH-1:0] sync1_q;
  logic [CH-1:0] sync2_q;

  // Two-flop synchroniser; keeps sampling regardless of iEn.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= {CH{INIT_L}};
      sync2_q <= {CH{INIT_L}};
    end else begin
      sync1_q <= iSig;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_q, sig_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             diff_s;

    assign diff_s = (sync2_q[g] != sig_q);

    // Per-channel state, counter, filtered level and edge pulses.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        sig_q   <= INIT_L;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sig_q   <= sig_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    // Next-state: count consecutive differing samples, commit on the NUM-th.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sig_d   = sig_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!iEn) begin
        state_d = STABLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          STABLE: begin
            if (diff_s) begin
              if (NUM == 1) begin
                // Single-sample filter commits on the first differing sample.
                sig_d   = sync2_q[g];
                rise_d  = sync2_q[g];
                fall_d  = ~sync2_q[g];
                cnt_d   = '0;
                state_d = STABLE;
              end else begin
                cnt_d   = ONE_CNT;
                state_d = PEND;
              end
            end else begin
              cnt_d = '0;
            end
          end
          PEND: begin
            if (!diff_s) begin
              // Input reverted before confirmation: treat as a glitch.
              cnt_d   = '0;
              state_d = STABLE;
            end else if (cnt_q == LAST_CNT) begin
              sig_d   = sync2_q[g];
              rise_d  = sync2_q[g];
              fall_d  = ~sync2_q[g];
              cnt_d   = '0;
              state_d = STABLE;
            end else begin
              cnt_d = cnt_q + ONE_CNT;
            end
          end
          default: begin
            cnt_d   = '0;
            state_d = STABLE;
          end
        endcase
      end
    end

    assign oSignal[g] = sig_q;
    assign oRise[g]   = rise_q;
    assign oFall[g]   = fall_q;
    assign oBusy[g]   = (state_q == PEND);
  end

endmodule
